// File: rtl/ser_pkg.sv
// ser_pkg: state encoding, idle-level default and counter sizing shared by the serial feeder
// and its neighbours.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    PAR
  } ser_state_e;

  localparam logic IDLE_LVL_DEFAULT = 1'b0;

  // clog2 with a floor of one bit, so zero-length counters still have a legal width
  function automatic int cnt_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/ser_bit_feeder.sv
// ser_bit_feeder: accepts a parallel word on valid/ready, shifts it out MSB first on ser_out
// and then holds IDLE_LVL for GAP_CYCLES cycles. Optional even-parity bit: SER_PARITY_EN.
module ser_bit_feeder
  import ser_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic        IDLE_LVL   = IDLE_LVL_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              ser_out,
  output logic              frame_start,
  output logic              busy
);

  localparam int CW = cnt_width(DATA_W);
  localparam int GW = cnt_width(GAP_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_W - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam ser_state_e POST_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

  ser_state_e        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic              ser_q, ser_d;
  logic              fs_q, fs_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
`ifdef SER_PARITY_EN
  logic              par_q, par_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      ser_q   <= IDLE_LVL;
      fs_q    <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      ser_q   <= ser_d;
      fs_q    <= fs_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Outputs are registered, so every *_d here is the value the line shows after the next edge.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    ser_d   = IDLE_LVL;
    fs_d    = 1'b0;
`ifdef SER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (rdy_q && din_valid) begin
          state_d = SHIFT;
          shreg_d = din;
          cnt_d   = CNT_LOAD;
          ser_d   = din[DATA_W-1];
          fs_d    = 1'b1;
`ifdef SER_PARITY_EN
          par_d   = ^din;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
`ifdef SER_PARITY_EN
          state_d = PAR;
          ser_d   = par_q;
`else
          state_d = POST_FRAME;
          gcnt_d  = GAP_LOAD;
`endif
        end else begin
          shreg_d = shreg_q << 1;
          ser_d   = shreg_q[DATA_W-2];
          cnt_d   = cnt_q - CW'(1);
        end
      end
`ifdef SER_PARITY_EN
      PAR: begin
        state_d = POST_FRAME;
        gcnt_d  = GAP_LOAD;
      end
`endif
      GAP: begin
        if (gcnt_q == '0) state_d = IDLE;
        else gcnt_d = gcnt_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
  end

  assign din_ready   = rdy_q;
  assign ser_out     = ser_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ser_bit_feeder.sv
// Bench for ser_bit_feeder: lane 0 uses GAP_CYCLES=2, lane 1 uses GAP_CYCLES=0; a queue model
// per lane is compared every cycle, plus directed literal expectations.
module tb_ser_bit_feeder;

  logic       clk = 1'b1;
  logic       rst = 1'b1;
  logic [7:0] din_s   [2];
  logic       valid_s [2];
  logic       rdy_s   [2];
  logic       ser_s   [2];
  logic       fs_s    [2];
  logic       busy_s  [2];
  int         errors = 0;
  int         checks = 0;

`ifdef SER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned GAPN = (g == 0) ? 2 : 0;

    ser_bit_feeder #(.DATA_W(8), .GAP_CYCLES(GAPN), .IDLE_LVL(1'b0)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din_s[g]),
      .din_valid  (valid_s[g]),
      .din_ready  (rdy_s[g]),
      .ser_out    (ser_s[g]),
      .frame_start(fs_s[g]),
      .busy       (busy_s[g])
    );

    // Model: an accepted word becomes a list of line levels {first, bit}; one is consumed per clock.
    logic [1:0] q[$];
    logic e_ser = 1'b0, e_fs = 1'b0, e_busy = 1'b0, e_rdy = 1'b0;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        q.delete();
        e_ser = 1'b0; e_fs = 1'b0; e_busy = 1'b0; e_rdy = 1'b0;
      end else begin
        if (e_rdy && valid_s[g] === 1'b1) begin
          for (int b = 7; b >= 0; b--) q.push_back({(b == 7) ? 1'b1 : 1'b0, din_s[g][b]});
`ifdef SER_PARITY_EN
          q.push_back({1'b0, ^din_s[g]});
`endif
          for (int i = 0; i < int'(GAPN); i++) q.push_back(2'b00);
        end
        if (q.size() > 0) begin
          {e_fs, e_ser} = q.pop_front();
          e_busy = 1'b1;
          e_rdy  = 1'b0;
        end else begin
          e_fs = 1'b0; e_ser = 1'b0; e_busy = 1'b0; e_rdy = 1'b1;
        end
      end
      #1;
      chk($sformatf("lane%0d ser_out", g), 32'(ser_s[g]), 32'(e_ser));
      chk($sformatf("lane%0d frame_start", g), 32'(fs_s[g]), 32'(e_fs));
      chk($sformatf("lane%0d busy", g), 32'(busy_s[g]), 32'(e_busy));
      chk($sformatf("lane%0d din_ready", g), 32'(rdy_s[g]), 32'(e_rdy));
    end
  end

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic accept(input int g, input logic [7:0] w);
    int n = 0;
    din_s[g]   = w;
    valid_s[g] = 1'b1;
    while (rdy_s[g] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("lane%0d accept within bound", g), 32'(n < 40), 32'd1);
    @(posedge clk);
    @(negedge clk);
    valid_s[g] = 1'b0;
  endtask

  // Samples n cycles at negedges, oldest sample ends up in the most significant position.
  task automatic grab(input int g, input int n, output logic [15:0] s, output logic [15:0] f,
                      output logic [15:0] r, output logic [15:0] b);
    s = '0; f = '0; r = '0; b = '0;
    for (int i = 0; i < n; i++) begin
      s = {s[14:0], ser_s[g]};
      f = {f[14:0], fs_s[g]};
      r = {r[14:0], rdy_s[g]};
      b = {b[14:0], busy_s[g]};
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s, f, r, b;
    din_s[0] = '0; din_s[1] = '0;
    valid_s[0] = 1'b0; valid_s[1] = 1'b0;
    rst = 1'b1;

    // reset held for 25 ns
    repeat (2) begin
      @(negedge clk);
      chk("reset ser_out", 32'(ser_s[0]), 32'd0);
      chk("reset busy", 32'(busy_s[0]), 32'd0);
      chk("reset frame_start", 32'(fs_s[0]), 32'd0);
      chk("reset din_ready", 32'(rdy_s[0]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready after release lane0", 32'(rdy_s[0]), 32'd1);
    chk("ready after release lane1", 32'(rdy_s[1]), 32'd1);

    // single frame B4 with two gap cycles
    accept(0, 8'hB4);
    grab(0, 11 + P, s, f, r, b);
    chk("B4 bits+gap", 32'(s), (P == 1) ? 32'hB40 : 32'h5A0);
    chk("B4 frame_start", 32'(f), (P == 1) ? 32'h800 : 32'h400);
    chk("B4 ready return", 32'(r), 32'h1);
    chk("B4 busy span", 32'(b), (P == 1) ? 32'hFFE : 32'h7FE);

    // no-gap lane: AA, ready 8 cycles after accept
    accept(1, 8'hAA);
    grab(1, 9 + P, s, f, r, b);
    chk("AA bits", 32'(s), (P == 1) ? 32'h2A8 : 32'h154);
    chk("AA frame_start", 32'(f), (P == 1) ? 32'h200 : 32'h100);
    chk("AA ready return", 32'(r), 32'h1);
    chk("AA busy span", 32'(b), (P == 1) ? 32'h3FE : 32'h1FE);

    // back-to-back with valid held high; din changes mid-frame
    din_s[0]   = 8'hFF;
    valid_s[0] = 1'b1;
    for (int i = 0; i < 40 && rdy_s[0] !== 1'b1; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    din_s[0] = 8'h01;
    grab(0, 11 + P, s, f, r, b);
    valid_s[0] = 1'b0;
    chk("b2b first frame", 32'(s), (P == 1) ? 32'hFF0 : 32'h7F8);
    chk("b2b first start", 32'(f), (P == 1) ? 32'h800 : 32'h400);
    chk("b2b idle ready", 32'(r), 32'h1);
    grab(0, 8 + P, s, f, r, b);
    chk("b2b second frame", 32'(s), (P == 1) ? 32'h003 : 32'h001);
    chk("b2b second start", 32'(f), (P == 1) ? 32'h100 : 32'h080);
    chk("b2b second ready", 32'(r), 32'h0);

    // mid-frame async reset
    accept(0, 8'hFF);
    repeat (4) @(negedge clk);
    chk("pre-reset bit", 32'(ser_s[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("async reset ser_out", 32'(ser_s[0]), 32'd0);
    chk("async reset busy", 32'(busy_s[0]), 32'd0);
    chk("async reset ready", 32'(rdy_s[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    grab(0, 2, s, f, r, b);
    chk("post-reset idle line", 32'(s), 32'h0);
    chk("post-reset ready", 32'(r), 32'h3);
    chk("post-reset busy", 32'(b), 32'h0);
    accept(0, 8'h0F);
    grab(0, 8, s, f, r, b);
    chk("0F fresh frame", 32'(s), 32'h0F);
    chk("0F frame_start", 32'(f), 32'h80);

`ifdef SER_PARITY_EN
    accept(0, 8'h07);
    grab(0, 12, s, f, r, b);
    chk("07 with parity", 32'(s), 32'h078);
    chk("07 ready return", 32'(r), 32'h1);
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ser_bit_feeder.md
Name: ser_bit_feeder

Overview:
- Upstream stage for the serial sequence-detector FSM: accepts a parallel word via valid/ready handshake and drives it out one bit per clock on a single serial line that connects to the detector's ina input.
- Adds a configurable idle gap between frames so the detector sees defined inter-frame levels.
- Replaces the random stimulus used so far with deterministic, framed bit streams (test source and in-system feeder).

Parameters:
- DATA_W, 8, parallel word width in bits; legal range 2..32.
- GAP_CYCLES, 2, idle-level cycles inserted after each frame; 0 means no gap.
- IDLE_LVL, 1'b0, level driven on ser_out when not shifting data.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous reset, active-high; all state cleared immediately on assertion.
- din  input  DATA_W  parallel word to serialize, MSB first.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit stream, drives detector ina.
- frame_start  output  1  one-cycle pulse coincident with the first data bit on ser_out.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values: state=IDLE, ser_out=IDLE_LVL, din_ready=0 while rst is high, then 1 from the first clock after release, frame_start=0, busy=0, shift register=0, bit counter=0.
- All outputs are registered; nothing is combinational from din/din_valid.
- States: IDLE, SHIFT, GAP (shared enum), plus PAR when SER_PARITY_EN is defined.
- IDLE: din_ready=1.
  - On din_valid&&din_ready at edge k: load shreg<=din, cnt<=DATA_W-1, go to SHIFT.
  - After edge k: ser_out=din[DATA_W-1], frame_start=1 for that cycle only, din_ready=0, busy=1.
- SHIFT: each edge shifts left, ser_out<=next bit.
  - Bit i (MSB=0) is valid after edge k+i.
  - When cnt==0, next state is GAP if GAP_CYCLES>0, else IDLE.
- GAP: ser_out=IDLE_LVL for exactly GAP_CYCLES cycles, then IDLE.
- Timing: din_ready reasserts DATA_W+GAP_CYCLES cycles after the accept edge. Minimum word period is DATA_W+GAP_CYCLES+1 cycles.
- Handshake rules:
  - din_valid while din_ready=0 is ignored; no queuing.
  - din is sampled only at the accept edge; changes during a frame have no effect.
- Bit counter width is $clog2(DATA_W); gap counter width is $clog2(GAP_CYCLES+1), minimum 1.
- Reset mid-frame: frame aborted immediately (async); ser_out=IDLE_LVL; no partial bits after release; the first accept after release starts a fresh frame.
- din_valid held high continuously: back-to-back frames, each separated by GAP_CYCLES idle cycles plus one IDLE cycle.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - After the LSB, state PAR drives one even-parity bit (XOR of the whole word) for one cycle, then GAP/IDLE.
  - Frame length becomes DATA_W+1 cycles.
  - din_ready reasserts one cycle later than without the feature.
- Undefined: no PAR state, no parity logic, timing exactly as above.

Decomposition:
- Shared package ser_pkg holds:
  - state enum typedef (IDLE, SHIFT, GAP, PAR);
  - IDLE_LVL default constant;
  - localparam function for counter width (clog2 with minimum 1).
- No sub-module needed; the optional gap counter is a few lines, kept inline.
- Top-level integration instantiates ser_bit_feeder, then the detector FSM, with ser_out connected to ina and a shared clk/rst.

Test Plan:
- Reset: rst=1 for 25 ns, then release -> ser_out=0, busy=0, frame_start=0 throughout reset; din_ready=1 one clock after release.
- Single frame, DATA_W=8, GAP_CYCLES=2: din=8'hB4 accepted at edge k -> ser_out=1,0,1,1,0,1,0,0 after edges k..k+7; frame_start high only after edge k; ser_out=0 for edges k+8..k+9; din_ready=1 after edge k+10.
- Back-to-back: din_valid held high with 8'hFF then 8'h01 -> second frame_start exactly 11 cycles after the first; gap bits are 0; din changes mid-frame do not alter ser_out.
- GAP_CYCLES=0: din=8'hAA -> 10101010 then IDLE; din_ready returns 8 cycles after accept.
- Mid-frame reset: assert rst after bit 3 of 8'hFF -> ser_out drops to 0 asynchronously; after release, 8'h0F is sent cleanly as 00001111.
- SER_PARITY_EN defined, din=8'h07 -> 00000111 followed by parity bit 1, then gap; din_ready returns at 8+1+GAP_CYCLES cycles after accept.
